// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, mux selects,
// FSM state encoding and the instruction classes produced by the opcode decoder.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] WB_SEL_ALU   = 3'b000;
  localparam logic [2:0] WB_SEL_LOAD  = 3'b001;
  localparam logic [2:0] WB_SEL_PC4   = 3'b010;
  localparam logic [2:0] WB_SEL_IMM   = 3'b011;
  localparam logic [2:0] WB_SEL_AUIPC = 3'b100;

  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_TRAP   = ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_FENCE,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
  } iclass_t;

  // Classes that do not write the register file leave the select untouched.
  function automatic logic [2:0] wb_sel_of(input iclass_t c, input logic [2:0] cur);
    case (c)
      CL_ALU:          return WB_SEL_ALU;
      CL_LOAD:         return WB_SEL_LOAD;
      CL_JAL, CL_JALR: return WB_SEL_PC4;
      CL_LUI:          return WB_SEL_IMM;
      CL_AUIPC:        return WB_SEL_AUIPC;
      default:         return cur;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_opcode_decode.sv
// Combinational opcode classifier; anything outside the supported RV32I set,
// SYSTEM included, is flagged illegal.
module rv32i_opcode_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass  = CL_ALU;
    illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: iclass = CL_ALU;
      OPC_LOAD:           iclass = CL_LOAD;
      OPC_STORE:          iclass = CL_STORE;
      OPC_BRANCH:         iclass = CL_BRANCH;
      OPC_FENCE:          iclass = CL_FENCE;
      OPC_JAL:            iclass = CL_JAL;
      OPC_JALR:           iclass = CL_JALR;
      OPC_LUI:            iclass = CL_LUI;
      OPC_AUIPC:          iclass = CL_AUIPC;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback,
// drives PC, RF and memory handshakes, and traps on illegal opcodes or bus timeouts.
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       imem_ack_i,
  input  logic       dmem_ack_i,
  output logic       imem_req_o,
  output logic       ir_we_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       rf_we_o,
  output logic [2:0] wb_sel_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       trap_o
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam bit              WD_EN  = (TIMEOUT != 0);

  state_t          state, state_next;
  iclass_t         iclass_q, iclass_next, dec_class;
  logic            dec_illegal;
  logic [2:0]      wb_sel_q, wb_sel_next;
  logic [TO_W-1:0] cnt, cnt_next;
  logic            wd_expired;

  rv32i_opcode_decode u_dec (
    .opcode  (opcode_i),
    .iclass  (dec_class),
    .illegal (dec_illegal)
  );

  assign wd_expired = WD_EN && (cnt == TO_LIM);
  assign wb_sel_o   = (state == S_TRAP) ? WB_SEL_ALU : wb_sel_q;
  assign trap_o     = (state == S_TRAP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      iclass_q <= CL_ALU;
      wb_sel_q <= WB_SEL_ALU;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      iclass_q <= iclass_next;
      wb_sel_q <= wb_sel_next;
      cnt      <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    iclass_next = iclass_q;
    wb_sel_next = wb_sel_q;
    cnt_next    = cnt;
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    rf_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = PC_SEL_PC4;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o    = 1'b1;
          state_next = S_DECODE;
        end else if (wd_expired) begin
          state_next = S_TRAP;
        end else begin
          cnt_next = cnt + TO_W'(1);
        end
      end
      S_DECODE: begin
        iclass_next = dec_class;
        wb_sel_next = wb_sel_of(dec_class, wb_sel_q);
        state_next  = dec_illegal ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (iclass_q)
          CL_BRANCH: begin
            pc_we_o    = 1'b1;
            pc_sel_o   = branch_taken_i ? PC_SEL_BR : PC_SEL_PC4;
            state_next = S_FETCH;
          end
          CL_FENCE: begin
            pc_we_o    = 1'b1;
            state_next = S_FETCH;
          end
          CL_LOAD, CL_STORE: state_next = S_MEM;
          default:           state_next = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (iclass_q == CL_STORE);
        if (dmem_ack_i) begin
          if (iclass_q == CL_STORE) begin
            pc_we_o    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (wd_expired) begin
          state_next = S_TRAP;
        end else begin
          cnt_next = cnt + TO_W'(1);
        end
      end
      S_WB: begin
        rf_we_o    = 1'b1;
        pc_we_o    = 1'b1;
        pc_sel_o   = (iclass_q == CL_JAL)  ? PC_SEL_BR :
                     (iclass_q == CL_JALR) ? PC_SEL_JALR : PC_SEL_PC4;
        state_next = S_FETCH;
      end
      default: ;
    endcase
    // Each wait state gets a fresh timeout budget on entry.
    if ((state_next == S_FETCH || state_next == S_MEM) && state_next != state)
      cnt_next = '0;
  end

endmodule
